// File: rtl/bmem_adapter_pkg.sv
// Shared types and defaults for the L2-to-bmem line/burst adapter.
package bmem_adapter_pkg;

  localparam int LINE_W_DEF       = 256;
  localparam int BEAT_W_DEF       = 64;
  localparam int BEATS_DEF        = 4;
  localparam int LINE_OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_BURST,
    RESP
  } state_t;

endpackage

// File: rtl/bmem_line_adapter_assembler.sv
// Counter-indexed beat register file that rebuilds a cache line from read beats.
// Writes one slot per enabled cycle; contents persist until a synchronous clear.
module line_beat_assembler
  import bmem_adapter_pkg::*;
#(
  parameter int BEAT_W = BEAT_W_DEF,
  parameter int BEATS  = BEATS_DEF,
  parameter int CNT_W  = $clog2(BEATS_DEF)
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      we,
  input  logic [CNT_W-1:0]          idx,
  input  logic [BEAT_W-1:0]         beat,
  output logic [BEATS*BEAT_W-1:0]   line
);

  logic [BEAT_W-1:0] slot_q [BEATS];
  logic [BEAT_W-1:0] slot_d [BEATS];

  always_comb begin
    for (int i = 0; i < BEATS; i++) begin
      slot_d[i] = slot_q[i];
      if (we && (idx == CNT_W'(i))) slot_d[i] = beat;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BEATS; i++) begin
      if (clr) slot_q[i] <= '0;
      else     slot_q[i] <= slot_d[i];
    end
  end

  always_comb begin
    line = '0;
    for (int i = 0; i < BEATS; i++) line[i*BEAT_W +: BEAT_W] = slot_q[i];
  end

endmodule

// File: rtl/bmem_line_adapter.sv
// Splits 256-bit L2 line reads/writes into 4x64-bit bmem bursts, one transaction in flight.
// Read: resp one cycle after 4th beat; write: beats advance only on bmem_ready, resp after last.
module bmem_line_adapter
  import bmem_adapter_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF,
  parameter int BEATS  = BEATS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  if (LINE_W != BEATS * BEAT_W) begin : g_bad_cfg
    $error("bmem_line_adapter: LINE_W must equal BEATS*BEAT_W");
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       line_q, line_d;
  logic [LINE_W-1:0] wbuf_q, wbuf_d;
  logic [31:0]       bmem_addr_q, bmem_addr_d;
  logic              bmem_read_q, bmem_read_d;
  logic              bmem_write_q, bmem_write_d;
  logic [BEAT_W-1:0] bmem_wdata_q, bmem_wdata_d;
  logic              dfp_resp_q, dfp_resp_d;
  logic              beat_we;
  logic [31:0]       req_line;
  int                nxt_beat;
  logic              unused_low_addr;

  assign req_line        = {dfp_addr[31:LINE_OFFSET_BITS], LINE_OFFSET_BITS'(0)};
  assign unused_low_addr = ^{dfp_addr[LINE_OFFSET_BITS-1:0], bmem_raddr[LINE_OFFSET_BITS-1:0]};

  // Beats tagged with another line (stale or foreign traffic) never land in the buffer.
  assign beat_we = (state_q == RD_DATA) && bmem_rvalid &&
                   (bmem_raddr[31:LINE_OFFSET_BITS] == line_q[31:LINE_OFFSET_BITS]);
  assign nxt_beat = int'(cnt_q) + 1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    wbuf_d       = wbuf_q;
    bmem_addr_d  = bmem_addr_q;
    bmem_read_d  = bmem_read_q;
    bmem_write_d = bmem_write_q;
    bmem_wdata_d = bmem_wdata_q;
    dfp_resp_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dfp_read) begin
          line_d      = req_line;
          bmem_addr_d = req_line;
          bmem_read_d = 1'b1;
          state_d     = RD_REQ;
        end else if (dfp_write) begin
          line_d       = req_line;
          wbuf_d       = dfp_wdata;
          bmem_addr_d  = req_line;
          bmem_write_d = 1'b1;
          bmem_wdata_d = dfp_wdata[BEAT_W-1:0];
          state_d      = WR_BURST;
        end
      end
      RD_REQ: begin
        if (bmem_ready) begin
          bmem_read_d = 1'b0;
          bmem_addr_d = '0;
          state_d     = RD_DATA;
        end
      end
      RD_DATA: begin
        if (beat_we) begin
          if (cnt_q == LAST) begin
            cnt_d      = '0;
            dfp_resp_d = 1'b1;
            state_d    = RESP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WR_BURST: begin
        if (bmem_ready) begin
          if (cnt_q == LAST) begin
            cnt_d        = '0;
            bmem_write_d = 1'b0;
            bmem_wdata_d = '0;
            bmem_addr_d  = '0;
            dfp_resp_d   = 1'b1;
            state_d      = RESP;
          end else begin
            cnt_d        = cnt_q + CNT_W'(1);
            bmem_wdata_d = wbuf_q[nxt_beat*BEAT_W +: BEAT_W];
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      line_q       <= '0;
      wbuf_q       <= '0;
      bmem_addr_q  <= '0;
      bmem_read_q  <= 1'b0;
      bmem_write_q <= 1'b0;
      bmem_wdata_q <= '0;
      dfp_resp_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      wbuf_q       <= wbuf_d;
      bmem_addr_q  <= bmem_addr_d;
      bmem_read_q  <= bmem_read_d;
      bmem_write_q <= bmem_write_d;
      bmem_wdata_q <= bmem_wdata_d;
      dfp_resp_q   <= dfp_resp_d;
    end
  end

  line_beat_assembler #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS),
    .CNT_W  (CNT_W)
  ) u_asm (
    .clk  (clk),
    .clr  (rst),
    .we   (beat_we),
    .idx  (cnt_q),
    .beat (bmem_rdata),
    .line (dfp_rdata)
  );

  assign bmem_addr  = bmem_addr_q;
  assign bmem_read  = bmem_read_q;
  assign bmem_write = bmem_write_q;
  assign bmem_wdata = bmem_wdata_q;
  assign dfp_resp   = dfp_resp_q;

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Directed bench for bmem_line_adapter: reads, backpressured writes, tag filtering, reset abort.
module tb_bmem_line_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bmem_line_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  // L2 must drop or change a request in the cycle after it is answered.
  a_rd_released: assert property (@(posedge clk) disable iff (rst)
    (dfp_resp && dfp_read) |=> !dfp_read);
  a_wr_released: assert property (@(posedge clk) disable iff (rst)
    (dfp_resp && dfp_write && !dfp_read) |=> !dfp_write);

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd"},    256'(bmem_read),  256'(0));
    chk({tag, "_wr"},    256'(bmem_write), 256'(0));
    chk({tag, "_addr"},  256'(bmem_addr),  256'(0));
    chk({tag, "_wdat"},  256'(bmem_wdata), 256'(0));
    chk({tag, "_resp"},  256'(dfp_resp),   256'(0));
    chk({tag, "_rdata"}, dfp_rdata,        256'(0));
  endtask

  logic [63:0]  t1 [4] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                           64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
  logic [63:0]  wb [4] = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B,
                           64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D};
  logic [63:0]  r4 [4] = '{64'h0100_0000_0000_0000, 64'h0100_0000_0000_0001,
                           64'h0100_0000_0000_0002, 64'h0100_0000_0000_0003};
  logic [63:0]  r5 [4] = '{64'h5500_0000_0000_0005, 64'h5511_0000_0000_0015,
                           64'h5522_0000_0000_0025, 64'h5533_0000_0000_0035};
  logic [63:0]  r6 [4] = '{64'h6600_0000_0000_0006, 64'h6611_0000_0000_0016,
                           64'h6622_0000_0000_0026, 64'h6633_0000_0000_0036};
  logic [63:0]  w5 [4] = '{64'h7000_0000_0000_0000, 64'h7000_0000_0000_0001,
                           64'h7000_0000_0000_0002, 64'h7000_0000_0000_0003};
  logic [63:0]  w_exp [6];
  logic         rdy_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [255:0] line1;
  logic [255:0] line_exp;

  initial begin
    rst = 1'b1; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    w_exp = '{wb[0], wb[1], wb[1], wb[2], wb[3], wb[3]};
    line1 = {t1[3], t1[2], t1[1], t1[0]};
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Read with ready always high.
    dfp_addr = 32'h0000_1234; dfp_read = 1'b1; bmem_ready = 1'b1;
    step();
    chk("t1_rd_req", 256'(bmem_read), 256'(1));
    chk("t1_addr",   256'(bmem_addr), 256'(32'h0000_1220));
    chk("t1_no_wr",  256'(bmem_write), 256'(0));
    step();
    chk("t1_rd_1cyc", 256'(bmem_read), 256'(0));
    for (int i = 0; i < 4; i++) begin
      chk("t1_no_early_resp", 256'(dfp_resp), 256'(0));
      bmem_raddr = 32'h0000_1220; bmem_rdata = t1[i]; bmem_rvalid = 1'b1;
      step();
    end
    bmem_rvalid = 1'b0;
    chk("t1_resp",  256'(dfp_resp), 256'(1));
    chk("t1_rdata", dfp_rdata, line1);
    step();
    dfp_read = 1'b0;
    chk("t1_resp_pulse", 256'(dfp_resp), 256'(0));
    step();

    // Write with backpressure 1,0,1,1,0,1.
    dfp_addr = 32'h0000_0080; dfp_wdata = {wb[3], wb[2], wb[1], wb[0]}; dfp_write = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      chk("t2_wr_vld",  256'(bmem_write), 256'(1));
      chk("t2_wdata",   256'(bmem_wdata), 256'(w_exp[i]));
      chk("t2_addr",    256'(bmem_addr),  256'(32'h0000_0080));
      chk("t2_no_resp", 256'(dfp_resp),   256'(0));
      bmem_ready = rdy_pat[i];
      step();
    end
    chk("t2_resp",      256'(dfp_resp),   256'(1));
    chk("t2_wr_done",   256'(bmem_write), 256'(0));
    chk("t2_rdata_kept", dfp_rdata, line1);
    step();
    dfp_write = 1'b0;
    chk("t2_resp_once", 256'(dfp_resp), 256'(0));
    step();

    // Stray rvalid while idle must not touch anything.
    bmem_raddr = 32'h0000_1220; bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF; bmem_rvalid = 1'b1;
    step();
    bmem_rvalid = 1'b0;
    chk("t2b_idle_rvalid_rdata", dfp_rdata, line1);
    chk("t2b_idle_rvalid_resp",  256'(dfp_resp), 256'(0));
    step();

    // Read held in RD_REQ for 3 cycles, then a mismatched beat mid-burst.
    dfp_addr = 32'h0000_0100; dfp_read = 1'b1; bmem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t3_rd_held",  256'(bmem_read), 256'(1));
      chk("t3_addr_held", 256'(bmem_addr), 256'(32'h0000_0100));
      bmem_ready = (i == 3);
      step();
    end
    chk("t3_accepted", 256'(bmem_read), 256'(0));
    bmem_raddr = 32'h0000_0100; bmem_rdata = r4[0]; bmem_rvalid = 1'b1;
    step();
    bmem_raddr = 32'h0000_0200; bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    line_exp = {t1[3], t1[2], t1[1], r4[0]};
    chk("t4_drop_rdata", dfp_rdata, line_exp);
    bmem_rvalid = 1'b0;
    step();
    bmem_rvalid = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk("t4_no_early_resp", 256'(dfp_resp), 256'(0));
      bmem_raddr = 32'h0000_0100 + 32'(i * 8); bmem_rdata = r4[i];
      step();
    end
    bmem_rvalid = 1'b0;
    chk("t4_resp",  256'(dfp_resp), 256'(1));
    chk("t4_rdata", dfp_rdata, {r4[3], r4[2], r4[1], r4[0]});
    step();
    dfp_read = 1'b0;
    step();

    // Read and write together: read first, write afterwards.
    dfp_addr = 32'h0000_0240; dfp_read = 1'b1; dfp_write = 1'b1;
    dfp_wdata = {w5[3], w5[2], w5[1], w5[0]}; bmem_ready = 1'b1;
    step();
    chk("t5_rd_first", 256'(bmem_read),  256'(1));
    chk("t5_no_wr",    256'(bmem_write), 256'(0));
    chk("t5_addr",     256'(bmem_addr),  256'(32'h0000_0240));
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_wr_in_rd", 256'(bmem_write), 256'(0));
      bmem_raddr = 32'h0000_0240; bmem_rdata = r5[i]; bmem_rvalid = 1'b1;
      step();
    end
    bmem_rvalid = 1'b0;
    chk("t5_rd_resp",  256'(dfp_resp), 256'(1));
    chk("t5_rd_rdata", dfp_rdata, {r5[3], r5[2], r5[1], r5[0]});
    step();
    dfp_read = 1'b0;
    chk("t5_idle_no_wr", 256'(bmem_write), 256'(0));
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t5_wr_vld",   256'(bmem_write), 256'(1));
      chk("t5_wr_wdata", 256'(bmem_wdata), 256'(w5[i]));
      step();
    end
    chk("t5_wr_resp",     256'(dfp_resp), 256'(1));
    chk("t5_rdata_after_wr", dfp_rdata, {r5[3], r5[2], r5[1], r5[0]});
    step();
    dfp_write = 1'b0;
    step();

    // Reset after two beats of a read, trailing beats ignored, then a clean read.
    dfp_addr = 32'h0000_0300; dfp_read = 1'b1;
    step(); step();
    for (int i = 0; i < 2; i++) begin
      bmem_raddr = 32'h0000_0300; bmem_rdata = r6[i]; bmem_rvalid = 1'b1;
      step();
    end
    rst = 1'b1; dfp_read = 1'b0; bmem_rdata = r6[2];
    step();
    chk_all_zero("t6_rst");
    rst = 1'b0; bmem_rdata = r6[3];
    step();
    bmem_rvalid = 1'b0;
    chk("t6_trail_rdata", dfp_rdata, 256'(0));
    chk("t6_trail_resp",  256'(dfp_resp), 256'(0));
    chk("t6_trail_rd",    256'(bmem_read), 256'(0));
    dfp_addr = 32'h0000_0340; dfp_read = 1'b1;
    step();
    chk("t6_new_addr", 256'(bmem_addr), 256'(32'h0000_0340));
    step();
    for (int i = 0; i < 4; i++) begin
      bmem_raddr = 32'h0000_0340; bmem_rdata = r6[i]; bmem_rvalid = 1'b1;
      step();
    end
    bmem_rvalid = 1'b0;
    chk("t6_new_resp",  256'(dfp_resp), 256'(1));
    chk("t6_new_rdata", dfp_rdata, {r6[3], r6[2], r6[1], r6[0]});
    step();
    dfp_read = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bmem_line_adapter.md
Name: bmem_line_adapter

Overview:
- Converts the L2 cache's downward-facing 256-bit line read/write requests into 4-beat, 64-bit burst transactions on the banked memory (bmem) port.
- Reassembles returned read beats into a full line.
- Sits directly downstream of the L1/L2 arbiter's L2 instance and replaces the ad-hoc burst counters currently inlined there.
- Supports one outstanding transaction at a time.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, bmem data beat width; LINE_W must equal BEATS*BEAT_W (elaboration-time check).
- BEATS, 4, beats per line burst.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- dfp_addr  in  32  line address from L2; bits [4:0] are ignored and forced to 0 internally
- dfp_read  in  1  line read request, level, held until dfp_resp
- dfp_write  in  1  line write request, level, held until dfp_resp
- dfp_wdata  in  256  write line, captured at acceptance
- dfp_rdata  out  256  assembled read line
- dfp_resp  out  1  one-cycle completion pulse
- bmem_addr  out  32  burst address, line aligned
- bmem_read  out  1  read burst request
- bmem_write  out  1  write beat valid
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  bmem accepts a request or beat this cycle
- bmem_raddr  in  32  address tag of the returning beat
- bmem_rdata  in  64  returning read beat
- bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset values: all outputs 0, state IDLE, beat counter 0, line buffers 0. Reset mid-burst aborts to IDLE immediately; any beats arriving afterwards are ignored.
- States:
  - IDLE: nothing driven. If dfp_read is high, latch {dfp_addr[31:5],5'b0} and go to RD_REQ. Else if dfp_write is high, latch the address and dfp_wdata and go to WR_BURST. Read wins when both are high.
  - RD_REQ: bmem_read=1, bmem_addr=latched line. Go to RD_DATA at the first edge where bmem_ready=1. bmem_read stays asserted while ready is low.
  - RD_DATA: on bmem_rvalid with bmem_raddr[31:5] equal to the latched line, store the beat at slot [cnt*64 +: 64] and increment cnt. Beats with a mismatched raddr are dropped. After beat BEATS-1 is stored, set cnt=0 and go to RESP.
  - WR_BURST: bmem_write=1, bmem_addr=line, bmem_wdata=wbuf[cnt*64 +: 64]. cnt advances only on an edge with bmem_ready=1; beat data holds stable while ready is low. After beat BEATS-1 is accepted, set cnt=0 and go to RESP.
  - RESP: dfp_resp=1 for exactly one cycle, then IDLE. Requests are not sampled in RESP.
- Upstream contract: L2 deasserts or changes its request in the cycle after dfp_resp. The bench asserts this.
- dfp_rdata: registered. Updated only by read beats and held stable from RESP until the next read's first beat. Not modified by writes.
- Minimum latencies:
  - Read: request seen in cycle 0, RD_REQ in cycle 1, beats no earlier than cycle 2, dfp_resp in the cycle after the 4th beat.
  - Write: beats in cycles 1-4 with ready high throughout, dfp_resp in cycle 5.
- bmem_rvalid outside RD_DATA is ignored; no state change.
- The beat counter is $clog2(BEATS) bits wide and wraps to 0 only via explicit clear.

Decomposition:
- Package bmem_adapter_pkg holds:
  - the state enum typedef (IDLE, RD_REQ, RD_DATA, WR_BURST, RESP);
  - LINE_W, BEAT_W and BEATS defaults;
  - the LINE_OFFSET_BITS=5 constant.
- One natural sub-module: line_beat_assembler. It is a counter-indexed 4x64 register file that writes a beat on enable, exposes the full line, and has synchronous clear.

Test Plan:
- Read, ready always 1: dfp_read, addr 0x0000_1234. Expect bmem_read for 1 cycle with bmem_addr 0x0000_1220. Return beats 0x11..,0x22..,0x33..,0x44.. on consecutive cycles. Expect dfp_resp 1 cycle later with dfp_rdata={0x44..,0x33..,0x22..,0x11..}.
- Write with backpressure: dfp_write, addr 0x80, wdata beats A,B,C,D; bmem_ready toggles 1,0,1,1,0,1. Expect bmem_wdata order A,B,B,C,D,D with the held beat stable, then dfp_resp exactly once after D is accepted.
- Read held at RD_REQ: bmem_ready=0 for 3 cycles. Expect bmem_read steady high and no advance; acceptance on the 4th cycle.
- Mismatched raddr: inject a beat with raddr 0x200 during a read of line 0x100. Expect it to be dropped, cnt unchanged, and the final line built only from 4 matching beats.
- Simultaneous dfp_read and dfp_write in IDLE: expect the read burst first with no bmem_write. After resp, with write still held, expect the write burst.
- rst asserted after beat 2 of a read: expect all outputs 0 next cycle and no dfp_resp. Trailing beats 3-4 are ignored, and a new read completes correctly.
